// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga pipeline: bus/register types, instruction
// field layouts, opcode constants and the fetch->decode->execute records.
package tartaruga_pkg;

    localparam int XLEN       = 32;
    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = $clog2(REG_COUNT);

    typedef logic [XLEN-1:0]       bus32_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [31:0]           instruction_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [6:0] F7_ADD     = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;

    // Zero encodings are chosen so a cleared control word is a harmless ADD.
    typedef enum logic { OP_RS1  = 1'b0, OP_PC   = 1'b1 } rs1_or_pc_t;
    typedef enum logic { OP_RS2  = 1'b0, OP_IMM  = 1'b1 } rs2_or_imm_t;
    typedef enum logic { ALU_ADD = 1'b0, ALU_SUB = 1'b1 } alu_op_t;
    typedef enum logic { RES_ALU = 1'b0, RES_MEM = 1'b1 } alu_or_mem_t;

    typedef struct packed {
        logic [6:0] func7;
        reg_addr_t  rs2;
        reg_addr_t  rs1;
        logic [2:0] func3;
        reg_addr_t  rd;
        logic [6:0] opcode;
    } rtype_t;

    typedef struct packed {
        logic [11:0] imm;
        reg_addr_t   rs1;
        logic [2:0]  func3;
        reg_addr_t   rd;
        logic [6:0]  opcode;
    } itype_t;

    typedef struct packed {
        logic [6:0] imm_hi;
        reg_addr_t  rs2;
        reg_addr_t  rs1;
        logic [2:0] func3;
        logic [4:0] imm_lo;
        logic [6:0] opcode;
    } stype_t;

    typedef struct packed {
        logic [19:0] imm;
        reg_addr_t   rd;
        logic [6:0]  opcode;
    } utype_t;

    typedef struct packed {
        bus32_t       pc;
        instruction_t instr;
    } fetch_to_decode_t;

    typedef struct packed {
        logic        write_enable;
        rs1_or_pc_t  rs1_or_pc;
        rs2_or_imm_t rs2_or_imm;
        alu_op_t     alu_op;
        alu_or_mem_t alu_or_mem;
        logic        store_to_mem;
    } control_t;

    typedef struct packed {
        bus32_t    pc;
        control_t  instr;
        reg_addr_t addr_rd;
        reg_addr_t addr_rs1;
        reg_addr_t addr_rs2;
        bus32_t    data_rs1;
        bus32_t    data_rs2;
        bus32_t    immediate;
    } decode_to_exe_t;

    function automatic bus32_t sext12(input logic [11:0] v);
        return {{(XLEN-12){v[11]}}, v};
    endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// Register file: REG_COUNT x 32, two async read ports, one write port, x0 hardwired
// to zero. Define WB_BYPASS_EN to forward the same-cycle write onto the read ports.
module register_file
    import tartaruga_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  reg_addr_t raddr1_i,
    input  reg_addr_t raddr2_i,
    output bus32_t    rdata1_o,
    output bus32_t    rdata2_o,
    input  logic      we_i,
    input  reg_addr_t waddr_i,
    input  bus32_t    wdata_i
);

    // Flops rather than block RAM: the whole file must clear on reset.
    bus32_t    regs_q [REG_COUNT];
    reg_addr_t raddr  [2];
    bus32_t    rdata  [2];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign raddr[0] = raddr1_i;
    assign raddr[1] = raddr2_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
`ifdef WB_BYPASS_EN
            assign rdata[gi] = (raddr[gi] == '0) ? '0 :
                               (we_i && (waddr_i == raddr[gi])) ? wdata_i :
                               regs_q[raddr[gi]];
`else
            assign rdata[gi] = (raddr[gi] == '0) ? '0 : regs_q[raddr[gi]];
`endif
        end
    endgenerate

    assign rdata1_o = rdata[0];
    assign rdata2_o = rdata[1];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes the fetched instruction, reads operands and registers the
// result for execute. WB_BYPASS_EN enables write-through forwarding in register_file.
module decode_stage
    import tartaruga_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  fetch_to_decode_t fetch_i,
    output logic             ready_o,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             wb_we_i,
    input  reg_addr_t        wb_addr_i,
    input  bus32_t           wb_data_i,
    output logic             valid_o,
    output decode_to_exe_t   decode_o,
    output logic             illegal_o
);

    rtype_t r_w;
    itype_t i_w;
    stype_t s_w;
    utype_t u_w;

    control_t       ctrl_d;
    bus32_t         imm_d;
    logic           illegal_d;
    reg_addr_t      raddr1_d;
    decode_to_exe_t decode_d;
    bus32_t         rdata1_w;
    bus32_t         rdata2_w;
    logic           accept_w;

    logic           valid_q;
    logic           illegal_q;
    decode_to_exe_t decode_q;

    assign r_w = rtype_t'(fetch_i.instr);
    assign i_w = itype_t'(fetch_i.instr);
    assign s_w = stype_t'(fetch_i.instr);
    assign u_w = utype_t'(fetch_i.instr);

    assign ready_o  = !stall_i;
    assign accept_w = valid_i && ready_o;

    always_comb begin
        ctrl_d    = '0;
        imm_d     = '0;
        illegal_d = 1'b0;
        raddr1_d  = r_w.rs1;
        case (r_w.opcode)
            OPC_OP: begin
                if ((r_w.func3 == F3_ADD_SUB) &&
                    ((r_w.func7 == F7_ADD) || (r_w.func7 == F7_SUB))) begin
                    ctrl_d.write_enable = 1'b1;
                    ctrl_d.rs2_or_imm   = OP_RS2;
                    ctrl_d.alu_op       = (r_w.func7 == F7_SUB) ? ALU_SUB : ALU_ADD;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                ctrl_d.write_enable = 1'b1;
                ctrl_d.rs2_or_imm   = OP_IMM;
                imm_d               = sext12(i_w.imm);
            end
            OPC_LUI: begin
                // rs1 forced to x0 so the ALU's ADD passes the U-immediate through.
                ctrl_d.write_enable = 1'b1;
                ctrl_d.rs2_or_imm   = OP_IMM;
                imm_d               = {u_w.imm, 12'b0};
                raddr1_d            = '0;
            end
            OPC_AUIPC: begin
                ctrl_d.write_enable = 1'b1;
                ctrl_d.rs1_or_pc    = OP_PC;
                ctrl_d.rs2_or_imm   = OP_IMM;
                imm_d               = {u_w.imm, 12'b0};
            end
            OPC_LOAD: begin
                ctrl_d.write_enable = 1'b1;
                ctrl_d.rs2_or_imm   = OP_IMM;
                ctrl_d.alu_or_mem   = RES_MEM;
                imm_d               = sext12(i_w.imm);
            end
            OPC_STORE: begin
                ctrl_d.store_to_mem = 1'b1;
                ctrl_d.rs2_or_imm   = OP_IMM;
                imm_d               = sext12({s_w.imm_hi, s_w.imm_lo});
            end
            default: begin
                illegal_d = 1'b1;
            end
        endcase
    end

    register_file u_register_file (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .raddr1_i (raddr1_d),
        .raddr2_i (r_w.rs2),
        .rdata1_o (rdata1_w),
        .rdata2_o (rdata2_w),
        .we_i     (wb_we_i),
        .waddr_i  (wb_addr_i),
        .wdata_i  (wb_data_i)
    );

    always_comb begin
        decode_d           = '0;
        decode_d.pc        = fetch_i.pc;
        decode_d.instr     = ctrl_d;
        decode_d.addr_rd   = r_w.rd;
        decode_d.addr_rs1  = raddr1_d;
        decode_d.addr_rs2  = r_w.rs2;
        decode_d.data_rs1  = rdata1_w;
        decode_d.data_rs2  = rdata2_w;
        decode_d.immediate = imm_d;
    end

    // Priority flush > stall > load; illegal_o is a pulse, so it never holds.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            decode_q  <= '0;
        end else if (flush_i) begin
            valid_q        <= 1'b0;
            illegal_q      <= 1'b0;
            decode_q.instr <= '0;
        end else if (stall_i) begin
            illegal_q <= 1'b0;
        end else if (accept_w) begin
            valid_q   <= 1'b1;
            illegal_q <= illegal_d;
            decode_q  <= decode_d;
        end else begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end
    end

    assign valid_o   = valid_q;
    assign illegal_o = illegal_q;
    assign decode_o  = decode_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: table vectors, directed corner sequences
// and randomized traffic checked against a behavioural model.
module tb_decode_stage;
    import tartaruga_pkg::*;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             valid_i;
    fetch_to_decode_t fetch;
    logic             ready_o;
    logic             stall_i;
    logic             flush_i;
    logic             wb_we_i;
    reg_addr_t        wb_addr_i;
    bus32_t           wb_data_i;
    logic             valid_o;
    decode_to_exe_t   decode_o;
    logic             illegal_o;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .fetch_i   (fetch),
        .ready_o   (ready_o),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .wb_we_i   (wb_we_i),
        .wb_addr_i (wb_addr_i),
        .wb_data_i (wb_data_i),
        .valid_o   (valid_o),
        .decode_o  (decode_o),
        .illegal_o (illegal_o)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    bus32_t         mregs [32];
    logic           exp_valid;
    logic           exp_illegal;
    logic           exp_dec_ill;
    logic           illegal_known;
    decode_to_exe_t exp_dec;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic bus32_t mread(input logic [4:0] a);
        if (a == 5'd0) return '0;
`ifdef WB_BYPASS_EN
        if (wb_we_i && (wb_addr_i == a)) return wb_data_i;
`endif
        return mregs[a];
    endfunction

    function automatic void ref_decode(input fetch_to_decode_t f,
                                       output decode_to_exe_t d, output logic ill);
        bus32_t w;
        bus32_t imm_i, imm_s, imm_u, hi;
        w     = f.instr;
        imm_i = bus32_t'($signed(w) >>> 20);
        hi    = bus32_t'($signed(w) >>> 25);
        imm_s = (hi << 5) | {27'd0, w[11:7]};
        imm_u = w & 32'hFFFF_F000;
        d = '0;
        ill = 1'b0;
        d.pc       = f.pc;
        d.addr_rd  = w[11:7];
        d.addr_rs1 = w[19:15];
        d.addr_rs2 = w[24:20];
        d.instr.write_enable = 1'b1;
        d.instr.rs2_or_imm   = OP_IMM;
        case (w[6:0])
            7'b0110011: begin
                d.instr.rs2_or_imm = OP_RS2;
                if (w[14:12] != 3'd0) ill = 1'b1;
                else if (w[31:25] == 7'h20) d.instr.alu_op = ALU_SUB;
                else if (w[31:25] != 7'h00) ill = 1'b1;
            end
            7'b0010011: d.immediate = imm_i;
            7'b0110111: begin d.immediate = imm_u; d.addr_rs1 = '0; end
            7'b0010111: begin d.immediate = imm_u; d.instr.rs1_or_pc = OP_PC; end
            7'b0000011: begin d.immediate = imm_i; d.instr.alu_or_mem = RES_MEM; end
            7'b0100011: begin
                d.immediate = imm_s;
                d.instr.write_enable = 1'b0;
                d.instr.store_to_mem = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            d.instr = '0;
            d.immediate = '0;
        end
        d.data_rs1 = mread(d.addr_rs1);
        d.data_rs2 = mread(w[24:20]);
    endfunction

    task automatic model_edge();
        decode_to_exe_t d;
        logic ill;
        if (flush_i) begin
            exp_valid = 1'b0; exp_illegal = 1'b0; exp_dec.instr = '0;
            exp_dec_ill = 1'b0; illegal_known = 1'b1;
        end else if (stall_i) begin
            illegal_known = 1'b0;
        end else if (valid_i) begin
            ref_decode(fetch, d, ill);
            exp_dec = d; exp_valid = 1'b1; exp_illegal = ill;
            exp_dec_ill = ill; illegal_known = 1'b1;
        end else begin
            exp_valid = 1'b0; exp_illegal = 1'b0; illegal_known = 1'b1;
        end
        if (wb_we_i && (wb_addr_i != '0)) mregs[wb_addr_i] = wb_data_i;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        exp_valid = 1'b0; exp_illegal = 1'b0; exp_dec = '0;
        exp_dec_ill = 1'b0; illegal_known = 1'b1;
    endtask

    task automatic step();
        #1;
        chk("ready", ready_o, !stall_i);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_out(input string name);
        chk({name, ".valid"}, valid_o, exp_valid);
        if (illegal_known) chk({name, ".illegal"}, illegal_o, exp_illegal);
        if (exp_valid && !exp_dec_ill) chk({name, ".decode"}, decode_o, exp_dec);
        else if (exp_valid) begin
            chk({name, ".we"}, decode_o.instr.write_enable, 1'b0);
            chk({name, ".store"}, decode_o.instr.store_to_mem, 1'b0);
        end
    endtask

    task automatic idle_inputs();
        valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        wb_we_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
        fetch = '0;
    endtask

    task automatic wb_write(input logic [4:0] a, input bus32_t v);
        idle_inputs();
        wb_we_i = 1'b1; wb_addr_i = a; wb_data_i = v;
        step();
        wb_we_i = 1'b0;
    endtask

    function automatic bus32_t rand_instr();
        logic [4:0] a, b, c;
        a = 5'($urandom); b = 5'($urandom); c = 5'($urandom);
        case ($urandom_range(0, 8))
            0: return {7'h00, a, b, 3'd0, c, OPC_OP};
            1: return {7'h20, a, b, 3'd0, c, OPC_OP};
            2: return {12'($urandom), b, 3'($urandom), c, OPC_OP_IMM};
            3: return {20'($urandom), c, OPC_LUI};
            4: return {20'($urandom), c, OPC_AUIPC};
            5: return {12'($urandom), b, 3'd2, c, OPC_LOAD};
            6: return {7'($urandom), a, b, 3'd2, 5'($urandom), OPC_STORE};
            7: return {7'($urandom), a, b, 3'($urandom), c, OPC_OP};
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        bus32_t instr;
        logic   ill;
        logic   we;
        logic   st;
        bus32_t imm;
        logic   pc_sel;
        logic   imm_sel;
        logic   sub;
        logic   mem;
    } vec_t;

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{32'h005280B3, 0, 1, 0, 32'h0000_0000, 0, 0, 0, 0}; // ADD x1,x5,x5
        tbl[1]  = '{32'h402081B3, 0, 1, 0, 32'h0000_0000, 0, 0, 1, 0}; // SUB x3,x1,x2
        tbl[2]  = '{32'hFFF00113, 0, 1, 0, 32'hFFFF_FFFF, 0, 1, 0, 0}; // ADDI x2,x0,-1
        tbl[3]  = '{32'h0021A423, 0, 0, 1, 32'h0000_0008, 0, 1, 0, 0}; // SW x2,8(x3)
        tbl[4]  = '{32'hABCDE237, 0, 1, 0, 32'hABCD_E000, 0, 1, 0, 0}; // LUI x4
        tbl[5]  = '{32'h12345297, 0, 1, 0, 32'h1234_5000, 1, 1, 0, 0}; // AUIPC x5
        tbl[6]  = '{32'hFFC12303, 0, 1, 0, 32'hFFFF_FFFC, 0, 1, 0, 1}; // LW x6,-4(x2)
        tbl[7]  = '{32'hFE502FA3, 0, 0, 1, 32'hFFFF_FFFF, 0, 1, 0, 0}; // SW x5,-1(x0)
        tbl[8]  = '{32'hFFFFFFFF, 1, 0, 0, 32'h0000_0000, 0, 0, 0, 0};
        tbl[9]  = '{32'h00209133, 1, 0, 0, 32'h0000_0000, 0, 0, 0, 0}; // func3=001
        tbl[10] = '{32'h00000000, 1, 0, 0, 32'h0000_0000, 0, 0, 0, 0};

        idle_inputs();
        rst_i = 1'b1;
        model_reset();
        #12;
        chk("rst.valid", valid_o, 1'b0);
        chk("rst.illegal", illegal_o, 1'b0);
        chk("rst.decode", decode_o, '0);
        chk("rst.ready", ready_o, 1'b1);
        @(posedge clk); #1;
        rst_i = 1'b0;

        // Operand setup: x5 for ADD, x27 to prove LUI ignores its rs1 field
        wb_write(5'd5, 32'h1234_5678);
        wb_write(5'd27, 32'h0000_0055);
        wb_write(5'd2, 32'h0000_0100);

        for (int k = 0; k < 11; k++) begin
            idle_inputs();
            valid_i     = 1'b1;
            fetch.instr = tbl[k].instr;
            fetch.pc    = 32'h100 + 32'(k * 4);
            step();
            $display("vec %0d instr=%08h valid=%0b illegal=%0b imm=%08h", k,
                     tbl[k].instr, valid_o, illegal_o, decode_o.immediate);
            chk("tbl.valid", valid_o, 1'b1);
            chk("tbl.illegal", illegal_o, tbl[k].ill);
            chk("tbl.we", decode_o.instr.write_enable, tbl[k].we);
            chk("tbl.store", decode_o.instr.store_to_mem, tbl[k].st);
            if (!tbl[k].ill) begin
                chk("tbl.imm", decode_o.immediate, tbl[k].imm);
                chk("tbl.pcsel", decode_o.instr.rs1_or_pc, tbl[k].pc_sel);
                chk("tbl.immsel", decode_o.instr.rs2_or_imm, tbl[k].imm_sel);
                chk("tbl.sub", decode_o.instr.alu_op, tbl[k].sub);
                chk("tbl.mem", decode_o.instr.alu_or_mem, tbl[k].mem);
            end
            cmp_out("tbl.model");
            if (k == 0) begin
                chk("add.rs1", decode_o.data_rs1, 32'h1234_5678);
                chk("add.rs2", decode_o.data_rs2, 32'h1234_5678);
            end
            if (k == 4) begin
                chk("lui.addr_rs1", decode_o.addr_rs1, 5'd0);
                chk("lui.data_rs1", decode_o.data_rs1, 32'd0);
            end
        end

        // Illegal pulse lasts one cycle
        idle_inputs();
        valid_i = 1'b1; fetch.instr = 32'hFFFF_FFFF;
        step();
        chk("ill.pulse", illegal_o, 1'b1);
        idle_inputs();
        step();
        $display("illegal pulse end illegal=%0b valid=%0b", illegal_o, valid_o);
        chk("ill.end", illegal_o, 1'b0);
        chk("idle.valid", valid_o, 1'b0);

        // Stall holds outputs for 3 cycles, then flush wins over stall
        idle_inputs();
        valid_i = 1'b1; fetch.instr = 32'hFFF00113; fetch.pc = 32'h200;
        step();
        for (int c = 0; c < 3; c++) begin
            stall_i = 1'b1; fetch.instr = 32'h402081B3; fetch.pc = 32'h300;
            #1;
            chk("stall.ready", ready_o, 1'b0);
            step();
            $display("stall cycle %0d valid=%0b imm=%08h", c, valid_o, decode_o.immediate);
            chk("stall.hold", decode_o, exp_dec);
            chk("stall.imm", decode_o.immediate, 32'hFFFF_FFFF);
            chk("stall.valid", valid_o, 1'b1);
        end
        flush_i = 1'b1;
        step();
        $display("flush+stall valid=%0b", valid_o);
        chk("flush.valid", valid_o, 1'b0);
        chk("flush.ctrl", decode_o.instr, '0);

        // Write x7 in the same cycle as reading it; then x0 write is ignored
        wb_write(5'd7, 32'h0000_1111);
        idle_inputs();
        valid_i = 1'b1; fetch.instr = {7'h00, 5'd7, 5'd7, 3'd0, 5'd1, OPC_OP};
        wb_we_i = 1'b1; wb_addr_i = 5'd7; wb_data_i = 32'h0000_DEAD;
        step();
        $display("wb-same-cycle data_rs1=%08h", decode_o.data_rs1);
`ifdef WB_BYPASS_EN
        chk("byp.rs1", decode_o.data_rs1, 32'h0000_DEAD);
`else
        chk("byp.rs1", decode_o.data_rs1, 32'h0000_1111);
`endif
        idle_inputs();
        valid_i = 1'b1; fetch.instr = {7'h00, 5'd7, 5'd0, 3'd0, 5'd1, OPC_OP};
        wb_we_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'd5;
        step();
        chk("x0.same", decode_o.data_rs1, 32'd0);
        chk("x7.after", decode_o.data_rs2, 32'h0000_DEAD);
        wb_we_i = 1'b0;
        step();
        chk("x0.after", decode_o.data_rs1, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            valid_i     = ($urandom_range(0, 3) != 0);
            stall_i     = ($urandom_range(0, 4) == 0);
            flush_i     = ($urandom_range(0, 11) == 0);
            wb_we_i     = $urandom_range(0, 1);
            wb_addr_i   = 5'($urandom);
            wb_data_i   = $urandom;
            fetch.instr = rand_instr();
            fetch.pc    = $urandom;
            step();
            $display("rnd %0d instr=%08h v=%0b s=%0b f=%0b -> valid=%0b ill=%0b",
                     n, fetch.instr, valid_i, stall_i, flush_i, valid_o, illegal_o);
            cmp_out("rnd");
        end

        // Async reset mid-stall: outputs clear before any clock edge
        idle_inputs();
        valid_i = 1'b1; fetch.instr = 32'h005280B3;
        step();
        stall_i = 1'b1;
        step();
        #2;
        rst_i = 1'b1; wb_we_i = 1'b1; wb_addr_i = 5'd9; wb_data_i = 32'hFFFF_0000;
        #1;
        $display("async reset valid=%0b illegal=%0b", valid_o, illegal_o);
        chk("arst.valid", valid_o, 1'b0);
        chk("arst.illegal", illegal_o, 1'b0);
        chk("arst.decode", decode_o, '0);
        model_reset();
        @(posedge clk); #1;
        idle_inputs();
        rst_i = 1'b0;
        for (int r = 0; r < 32; r++) begin
            idle_inputs();
            valid_i = 1'b1;
            fetch.instr = {7'h00, 5'(r), 5'(r), 3'd0, 5'd0, OPC_OP};
            step();
            chk("arst.reg", decode_o.data_rs1, 32'd0);
            cmp_out("arst.read");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have port clk_i input 1: single clock, all state updates on rising edge.
REQ-002 SHALL have port rst_i input 1: reset, asynchronous, active-high.
REQ-003 SHALL have port valid_i input 1: fetch presents a valid instruction this cycle.
REQ-004 SHALL have port fetch_i input fetch_to_decode_t: pc (bus32_t) plus instr (instruction_t) from fetch.
REQ-005 SHALL have port ready_o output 1: decode accepts fetch_i this cycle.
REQ-006 SHALL have port stall_i input 1: downstream hazard; hold output register.
REQ-007 SHALL have port flush_i input 1: squash instruction held in output register.
REQ-008 SHALL have port wb_we_i input 1: writeback register-file write enable.
REQ-009 SHALL have port wb_addr_i input reg_addr_t: writeback destination.
REQ-010 SHALL have port wb_data_i input bus32_t: writeback data.
REQ-011 SHALL have port valid_o output 1: decode_o holds a valid instruction.
REQ-012 SHALL have port decode_o output decode_to_exe_t: registered decoded instruction, operands, immediate.
REQ-013 SHALL have port illegal_o output 1: one-cycle pulse, accepted instruction was unsupported.

Function
REQ-014 SHALL drive ready_o = !stall_i, combinationally.
REQ-015 SHALL accept fetch_i when valid_i && ready_o; latency 1 cycle: decode_o/valid_o update on the next edge.
REQ-016 SHALL apply per-edge priority flush_i > stall_i > load: flush clears valid_o and zeroes decode_o.instr control fields; stall holds all outputs; load captures new decode; otherwise (valid_i=0, no stall) valid_o SHALL go 0.
REQ-017 SHALL decode opcodes: 0110011 (ADD func7=0000000, SUB func7=0100000, func3=000), 0010011 ADDI, 0110111 LUI, 0010111 AUIPC, 0000011 LW, 0100011 SW.
REQ-018 SHALL set control: write_enable=1 except SW; rs1_or_pc=PC only AUIPC; rs2_or_imm=RS2 only R-type; alu_op=SUB only SUB else ADD; alu_or_mem=MEM only LW; store_to_mem=1 only SW.
REQ-019 SHALL generate immediate: I-type sign-extended [31:20]; S-type sign-extended {[31:25],[11:7]}; U-type {[31:12],12'b0}; R-type 0.
REQ-020 SHALL treat LUI as rs1 forced to x0 (addr_rs1=0, data_rs1=0) so ADD with immediate yields the U-immediate.
REQ-021 SHALL decode any other encoding as NOP (write_enable=0, store_to_mem=0), keep valid_o=1, and pulse illegal_o for one cycle.
REQ-022 SHALL read data_rs1/data_rs2 from a 32x32 register file; x0 SHALL read 0 always; writes to x0 SHALL be ignored.
REQ-023 SHALL write the register file on the rising edge when wb_we_i=1, independent of stall_i/flush_i.
REQ-024 SHALL, while stalled, keep data_rs1/data_rs2 frozen (no re-read); hazard resolution is upstream's responsibility.

Reset
REQ-025 SHALL on rst_i assertion immediately force valid_o=0, illegal_o=0, decode_o all-zero, all registers x1..x31 to 0.
REQ-026 SHALL discard any write or accept coincident with rst_i; first accept possible on first edge after deassertion.

Configuration
REQ-027 SHALL, with WB_BYPASS_EN defined, forward wb_data_i onto data_rs1/data_rs2 when wb_we_i=1, wb_addr_i equals the source address and is nonzero (write-through, same cycle).
REQ-028 SHALL, without WB_BYPASS_EN, read the pre-write register value in the same cycle as a matching write.

Structure
REQ-029 SHALL add fetch_to_decode_t, itype_t, stype_t and opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE) to tartaruga_pkg, using REG_COUNT.
REQ-030 SHALL place the register file in sub-module register_file (2 read, 1 write, async reset, bypass inside under WB_BYPASS_EN).

Verification
REQ-031 SHALL cover: write x5=0x12345678 then ADD x1,x5,x5 (0x005280B3) -> next cycle valid_o=1, data_rs1=data_rs2=0x12345678, alu_op=ADD, rs2_or_imm=RS2.
REQ-032 SHALL cover: ADDI x2,x0,-1 (0xFFF00113) -> immediate=0xFFFFFFFF; SW x2,8(x3) (0x0021A423) -> immediate=0x8, store_to_mem=1, write_enable=0.
REQ-033 SHALL cover: LUI x4,0xABCDE (0xABCDE237) -> immediate=0xABCDE000, addr_rs1=0, data_rs1=0.
REQ-034 SHALL cover: stall_i=1 for 3 cycles with valid_i=1 -> ready_o=0, decode_o unchanged; flush_i with stall_i same cycle -> valid_o=0 next edge.
REQ-035 SHALL cover: wb write x7=0xDEAD same cycle as read x7 -> data_rs1=0xDEAD with WB_BYPASS_EN, old value without; write x0=5 -> x0 reads 0.
REQ-036 SHALL cover: 0xFFFFFFFF accepted -> illegal_o pulses 1 cycle, write_enable=0; rst_i asserted mid-stall -> valid_o=0 immediately, all registers read 0.
